// File: rtl/umult_pkg.sv
// umult_pkg: shared types and constants for the sequential shift-add multiplier.
package umult_pkg;
    localparam int UMULT_W = 32;
    typedef enum logic [1:0] {IDLE, RUN, DONE} umult_st_t;
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/umult_if.sv
// umult_if: start/operand/result bundle between the multiplier and its ALU-side user.
interface umult_if import umult_pkg::*; #(parameter int WIDTH = UMULT_W) ();
    logic             strt;
    logic [WIDTH-1:0] inps;
    logic [WIDTH-1:0] inpt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] mout;
    logic [WIDTH-1:0] mhi;
    modport master (output strt, inps, inpt, input busy, done, mout, mhi);
    modport slave (input strt, inps, inpt, output busy, done, mout, mhi);
endinterface

// File: rtl/umult_addsh.sv
// umult_addsh: one radix-2 step, conditional add of mcand then right shift of {sum,plier}.
module umult_addsh import umult_pkg::*; #(parameter int WIDTH = UMULT_W) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_plier,
    input  logic [WIDTH-1:0] i_mcand,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_plier
);
    logic [WIDTH:0] w_sum;
    // the extra top bit keeps the carry so the product stays exact
    assign w_sum   = {1'b0, i_acc} + (i_plier[0] ? {1'b0, i_mcand} : '0);
    assign o_acc   = w_sum[WIDTH:1];
    assign o_plier = {w_sum[0], i_plier[WIDTH-1:1]};
endmodule

// File: rtl/umult.sv
// umult: sequential unsigned multiplier, one multiplier bit per clock, product in {mhi,mout}.
module umult import umult_pkg::*; #(parameter int WIDTH = UMULT_W) (
    input logic   clk,
    input logic   rst,
    umult_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);
    umult_st_t        r_st, w_st_nx;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc, r_plier, r_mcand;
    logic [WIDTH-1:0] w_acc_nx, w_plier_nx;
    logic             w_last;

    umult_addsh #(.WIDTH(WIDTH)) u_addsh (
        .i_acc   (r_acc),
        .i_plier (r_plier),
        .i_mcand (r_mcand),
        .o_acc   (w_acc_nx),
        .o_plier (w_plier_nx)
    );

    assign w_last = r_cnt == CW'(WIDTH - 1);

    always_comb begin
        w_st_nx = r_st;
        unique case (r_st)
            IDLE:    w_st_nx = bus.strt ? RUN : IDLE;
            RUN:     w_st_nx = w_last ? DONE : RUN;
            DONE:    w_st_nx = IDLE;
            default: w_st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st    <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_plier <= '0;
            r_mcand <= '0;
        end else begin
            r_st <= w_st_nx;
            if (r_st == IDLE && bus.strt) begin
                r_mcand <= bus.inps;
                r_plier <= bus.inpt;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (r_st == RUN) begin
                r_acc   <= w_acc_nx;
                r_plier <= w_plier_nx;
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.busy = r_st == RUN;
    assign bus.done = r_st == DONE;
    assign bus.mout = r_plier;
    assign bus.mhi  = r_acc;
endmodule

// File: tb/tb_umult.sv
// tb_umult: randomized self-checking bench for umult against an arithmetic product model.
module tb_umult;
    import umult_pkg::*;
    localparam int W  = UMULT_W;
    localparam int W2 = 2 * W;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    umult_if #(.WIDTH(W)) bus ();
    umult #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [W2-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        return W2'(a) * W2'(b);
    endfunction

    task automatic chk(input string tag, input logic [W2-1:0] got, input logic [W2-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start a multiply, optionally poke strt at RUN cycles 5 and 20, and check the result
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W2-1:0] exp, input bit disturb);
        int k;
        bus.strt = 1'b1;
        bus.inps = a;
        bus.inpt = b;
        tick();
        bus.strt = 1'b0;
        chk("busy_start", W2'(bus.busy), W2'(1));
        k = 0;
        while (!bus.done && k < W + 4) begin
            bus.inps = $urandom;
            bus.inpt = $urandom;
            bus.strt = disturb && (k == 4 || k == 19);
            tick();
            k++;
            chk("busy_done_excl", W2'(bus.busy & bus.done), W2'(0));
        end
        bus.strt = 1'b0;
        chk("latency", W2'(k), W2'(W));
        chk("busy_at_done", W2'(bus.busy), W2'(0));
        chk("product", {bus.mhi, bus.mout}, exp);
        tick();
        chk("done_pulse", W2'(bus.done), W2'(0));
        chk("hold", {bus.mhi, bus.mout}, exp);
    endtask

    task automatic b2b();
        logic [W-1:0] a, b;
        int cyc, last, idx;
        cyc = 0;
        last = -1;
        idx = 0;
        a = $urandom;
        b = $urandom;
        bus.strt = 1'b1;
        bus.inps = a;
        bus.inpt = b;
        while (idx < 3 && cyc < 200) begin
            tick();
            cyc++;
            if (bus.done) begin
                chk("b2b_product", {bus.mhi, bus.mout}, ref_mul(a, b));
                if (last >= 0) chk("b2b_gap", W2'(cyc - last), W2'(W + 2));
                last = cyc;
                idx++;
                bus.strt = idx < 3;
                tick();
                cyc++;
                chk("b2b_hold", {bus.mhi, bus.mout}, ref_mul(a, b));
                a = $urandom;
                b = $urandom;
                bus.inps = a;
                bus.inpt = b;
            end
        end
        bus.strt = 1'b0;
        chk("b2b_count", W2'(idx), W2'(3));
    endtask

    initial begin
        logic [W-1:0] a, b;
        rst = 1'b1;
        bus.strt = 1'b0;
        bus.inps = '0;
        bus.inpt = '0;
        repeat (2) tick();
        chk("rst_busy", W2'(bus.busy), W2'(0));
        chk("rst_done", W2'(bus.done), W2'(0));
        chk("rst_out", {bus.mhi, bus.mout}, W2'(0));
        rst = 1'b0;
        tick();
        run_mul(32'd3, 32'd5, 64'd15, 1'b0);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_mul(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b0);
        run_mul(32'h8000_0000, 32'd0, 64'd0, 1'b0);
        run_mul(32'd1234, 32'd5678, 64'd7006652, 1'b1);
        bus.strt = 1'b1;
        bus.inps = 32'hDEAD_BEEF;
        bus.inpt = 32'h1234_5678;
        tick();
        bus.strt = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        #1;
        chk("midrun_rst_busy", W2'(bus.busy), W2'(0));
        chk("midrun_rst_done", W2'(bus.done), W2'(0));
        chk("midrun_rst_out", {bus.mhi, bus.mout}, W2'(0));
        tick();
        rst = 1'b0;
        tick();
        run_mul(32'd7, 32'd9, 64'd63, 1'b0);
        b2b();
        tick();
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 7 == 0) a = a >> $urandom_range(0, W - 1);
            run_mul(a, b, ref_mul(a, b), $urandom_range(0, 3) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/umult.md
# umult

Sequential unsigned multiplier sitting directly upstream of the ALU. It multiplies two WIDTH-bit unsigned operands (the ALU's source S and T values) using a radix-2 shift-add loop, one bit per clock. It presents the low product word as the ALU's M input for opcode-selected writeback, and the high word for a separate move-from-high path.

## Interface
- `WIDTH`, default 32: operand width and width of each product half.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `strt`  in  1  start request; sampled only in IDLE.
- `inps`  in  WIDTH  multiplicand (ALU source S operand).
- `inpt`  in  WIDTH  multiplier (ALU source T operand).
- `busy`  out  1  high while a multiply is in progress (RUN state).
- `done`  out  1  single-cycle pulse when the product becomes valid.
- `mout`  out  WIDTH  product bits [WIDTH-1:0]; drives ALU `inpm`.
- `mhi`  out  WIDTH  product bits [2*WIDTH-1:WIDTH].

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `strt`=1 at an edge: load mcand←`inps`, plier←`inpt`, acc←0, cnt←0; go to RUN.
  - `strt`=0: stay in IDLE.
- RUN, each edge:
  - If plier[0]=1: form sum = {1'b0,acc} + {1'b0,mcand}, WIDTH+1 bits with carry. Otherwise sum = {1'b0,acc}.
  - Shift {sum,plier} right by 1: acc←sum[WIDTH:1], plier←{sum[0],plier[WIDTH-1:1]}.
  - cnt←cnt+1.
  - When cnt = WIDTH-1 at the edge, go to DONE. RUN therefore lasts exactly WIDTH edges.
- DONE: `done`=1 for one cycle; next edge goes to IDLE.
- Outputs: `mhi`=acc, `mout`=plier, driven directly from registers. After DONE both hold their value until the next accepted `strt`.
- `strt` is ignored in RUN and DONE; no queueing.
- Operands are captured at the start edge. Later changes on `inps`/`inpt` have no effect on the product.
- No overflow is possible: the full 2·WIDTH product is always exact. Carry out of the WIDTH-bit add is kept in sum[WIDTH].
- `rst` asserted at any time, including mid-RUN: immediately forces IDLE, cnt=0, acc=0, plier=0, mcand=0. The partial product is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `mout`=0, `mhi`=0.
- Start accepted at edge E0 → `busy`=1 from E0 through E0+WIDTH.
- `busy` falls at edge E0+WIDTH; `done`=1 during the cycle after E0+WIDTH.
- `mout`/`mhi` hold the final product from edge E0+WIDTH onward.
- Latency from start edge to valid product: WIDTH edges. The next start can be accepted at E0+WIDTH+2, giving a throughput of one multiply per WIDTH+2 cycles.
- `busy` and `done` are never high in the same cycle.
- Intermediate values of `mout`/`mhi` during RUN are visible but undefined for consumers. The consumer samples only on or after `done`.

## Structure
- Package `umult_pkg`:
  - state enum `umult_st_t` {IDLE, RUN, DONE};
  - default width constant `UMULT_W`=32;
  - counter width `$clog2(WIDTH)`.
- One natural sub-module, `umult_addsh`: combinational conditional-add plus right-shift step. It takes acc, plier, mcand and returns next acc and plier.
- The top module holds the FSM, counter and registers.

## Test plan
- Reset, then `strt` with `inps`=3, `inpt`=5 → `done` pulse 33 cycles after the start edge; `mhi`=0, `mout`=15.
- `inps`=`inpt`=0xFFFFFFFF → `mhi`=0xFFFFFFFE, `mout`=0x00000001; the carry path is exercised.
- `inps`=0x80000000, `inpt`=2 → `mhi`=1, `mout`=0; then `inpt`=0 → product 0, `done` still after WIDTH+1 cycles.
- Pulse `strt` with new operands at cycles 5 and 20 of a RUN → ignored; the first product completes unchanged.
- Assert `rst` at cycle 10 of RUN → `busy`/`done`/`mout`/`mhi` go to 0 immediately. A fresh 7×9 after release → `mout`=63.
- Back-to-back: hold `strt` high continuously → starts accepted every 34 cycles. `mout` is stable between `done` and the next start edge. Random operands are checked against a reference model over 1000 products.
